// File: rtl/digit_serial_add_ctrl_if.sv
// Requester-side bus of digit_serial_add_ctrl (start/ready/done handshake, operands, result).
// Macro DSA_OVERFLOW_EN adds the registered signed-overflow flag ovf.
interface digit_serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef DSA_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, cin, input ready, busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/digit_serial_add_ctrl.sv
// Digit-serial WIDTH-bit adder sequencer driving an external 2-bit ripple slice, LSB digit first.
// Optional macro DSA_OVERFLOW_EN adds the registered two's-complement overflow output req.ovf.
module digit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_add_ctrl_if.slave req,
  output logic [1:0]           slice_a,
  output logic [1:0]           slice_b,
  output logic                 slice_cin,
  input  logic [1:0]           slice_s,
  input  logic                 slice_cout
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CNT_W-1:0] cnt;
  logic             last_digit;
  logic             ready_c;
  logic             busy_c;
  logic             done_c;

  assign last_digit = (cnt == LAST_CNT);
  // New digit enters at the top; after DIGITS shifts acc holds the whole sum.
  assign acc_nxt    = WIDTH'({slice_s, acc} >> 2);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req.start) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_c   = (state == IDLE);
    busy_c    = (state == RUN);
    done_c    = (state == DONE);
    slice_a   = 2'b00;
    slice_b   = 2'b00;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = sa[1:0];
      slice_b   = sb[1:0];
      slice_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (state == IDLE) begin
      if (req.start) begin
        sa    <= req.a;
        sb    <= req.b;
        carry <= req.cin;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      sa    <= sa >> 2;
      sb    <= sb >> 2;
      carry <= slice_cout;
      acc   <= acc_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last_digit) begin
        sum_r  <= acc_nxt;
        cout_r <= slice_cout;
      end
    end
  end

`ifdef DSA_OVERFLOW_EN
  logic ovf_r;
  logic carry_into_msb;

  // On the last digit sa/sb hold the top digit, so bit 1 is the operand MSB.
  assign carry_into_msb = sa[1] ^ sb[1] ^ slice_s[1];

  always_ff @(posedge clk) begin
    if (!rst_n)                        ovf_r <= 1'b0;
    else if (state == RUN && last_digit) ovf_r <= carry_into_msb ^ slice_cout;
  end

  assign req.ovf = ovf_r;
`endif

  assign req.ready = ready_c;
  assign req.busy  = busy_c;
  assign req.done  = done_c;
  assign req.sum   = sum_r;
  assign req.cout  = cout_r;

endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
// Bench for digit_serial_add_ctrl: WIDTH=8 and WIDTH=2 instances against an arithmetic transaction model.
module tb_digit_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_n_d [2];
  logic       start_d [2];
  logic [7:0] a_d     [2];
  logic [7:0] b_d     [2];
  logic       cin_d   [2];
  bit         fin2 = 1'b0;

  digit_serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  digit_serial_add_ctrl_if #(.WIDTH(2)) if2 ();

  logic [1:0] sa8, sb8, ss8, sa2, sb2, ss2;
  logic       sc8, co8, sc2, co2;

  assign if8.start = start_d[0];
  assign if8.a     = a_d[0];
  assign if8.b     = b_d[0];
  assign if8.cin   = cin_d[0];
  assign if2.start = start_d[1];
  assign if2.a     = a_d[1][1:0];
  assign if2.b     = b_d[1][1:0];
  assign if2.cin   = cin_d[1];

  // The shared 2-bit ripple slice, one per instance.
  assign {co8, ss8} = 3'(sa8) + 3'(sb8) + 3'(sc8);
  assign {co2, ss2} = 3'(sa2) + 3'(sb2) + 3'(sc2);

  digit_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n_d[0]), .req(if8.slave),
    .slice_a(sa8), .slice_b(sb8), .slice_cin(sc8), .slice_s(ss8), .slice_cout(co8));

  digit_serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n_d[1]), .req(if2.slave),
    .slice_a(sa2), .slice_b(sb2), .slice_cin(sc2), .slice_s(ss2), .slice_cout(co2));

  logic       act_ready [2], act_busy [2], act_done [2], act_cout [2], act_scin [2];
  logic [7:0] act_sum   [2];
  logic [1:0] act_sa    [2], act_sb [2];
  assign act_ready[0] = if8.ready;  assign act_ready[1] = if2.ready;
  assign act_busy[0]  = if8.busy;   assign act_busy[1]  = if2.busy;
  assign act_done[0]  = if8.done;   assign act_done[1]  = if2.done;
  assign act_cout[0]  = if8.cout;   assign act_cout[1]  = if2.cout;
  assign act_sum[0]   = if8.sum;    assign act_sum[1]   = {6'd0, if2.sum};
  assign act_sa[0]    = sa8;        assign act_sa[1]    = sa2;
  assign act_sb[0]    = sb8;        assign act_sb[1]    = sb2;
  assign act_scin[0]  = sc8;        assign act_scin[1]  = sc2;
`ifdef DSA_OVERFLOW_EN
  logic act_ovf [2];
  assign act_ovf[0] = if8.ovf;
  assign act_ovf[1] = if2.ovf;
`endif

  function automatic int wd(input int i);  return (i == 0) ? 8 : 2;           endfunction
  function automatic int dg(input int i);  return wd(i) / 2;                  endfunction
  function automatic int msk(input int i); return (1 << wd(i)) - 1;           endfunction

  task automatic lit(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL w%0d %s: got %0h expected %0h", wd(i), nm, act, exp);
    end
  endtask

  // Transaction model: ph=0 idle, 1..DIGITS processing digit ph-1, DIGITS+1 done.
  int ph [2];
  int opa [2], opb [2], opc [2];
  int e_sum [2], e_cout [2], e_ovf [2];
  bit armed [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; opa[i] = 0; opb[i] = 0; opc[i] = 0;
      e_sum[i] = 0; e_cout[i] = 0; e_ovf[i] = 0; armed[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n_d[i] === 1'b0) begin
        ph[i]     <= 0;
        e_sum[i]  <= 0;
        e_cout[i] <= 0;
        e_ovf[i]  <= 0;
        armed[i]  <= 1'b1;
      end else if (ph[i] == 0) begin
        if (start_d[i] === 1'b1) begin
          ph[i]  <= 1;
          opa[i] <= int'(a_d[i]) & msk(i);
          opb[i] <= int'(b_d[i]) & msk(i);
          opc[i] <= int'(cin_d[i]);
        end
      end else if (ph[i] == dg(i)) begin
        e_sum[i]  <= (opa[i] + opb[i] + opc[i]) & msk(i);
        e_cout[i] <= (opa[i] + opb[i] + opc[i]) >> wd(i);
        e_ovf[i]  <= int'((((opa[i] >> (wd(i) - 1)) & 1) == ((opb[i] >> (wd(i) - 1)) & 1)) &&
                          ((((opa[i] + opb[i] + opc[i]) >> (wd(i) - 1)) & 1) != ((opa[i] >> (wd(i) - 1)) & 1)));
        ph[i]     <= dg(i) + 1;
      end else if (ph[i] < dg(i)) begin
        ph[i] <= ph[i] + 1;
      end else begin
        ph[i] <= 0;
      end
    end
  end

  int  cmp_k, cmp_mk;
  bit  cmp_run;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (armed[i]) begin
        cmp_run = (ph[i] >= 1) && (ph[i] <= dg(i));
        cmp_k   = cmp_run ? ph[i] - 1 : 0;
        cmp_mk  = (1 << (2 * cmp_k)) - 1;
        lit(i, "ready", 32'(act_ready[i]), 32'(ph[i] == 0));
        lit(i, "busy",  32'(act_busy[i]),  32'(cmp_run));
        lit(i, "done",  32'(act_done[i]),  32'(ph[i] == dg(i) + 1));
        lit(i, "sum",   32'(act_sum[i]),   32'(e_sum[i]));
        lit(i, "cout",  32'(act_cout[i]),  32'(e_cout[i]));
        lit(i, "slice_a", 32'(act_sa[i]),
            cmp_run ? 32'((opa[i] >> (2 * cmp_k)) & 3) : 32'd0);
        lit(i, "slice_b", 32'(act_sb[i]),
            cmp_run ? 32'((opb[i] >> (2 * cmp_k)) & 3) : 32'd0);
        lit(i, "slice_cin", 32'(act_scin[i]),
            cmp_run ? 32'(((opa[i] & cmp_mk) + (opb[i] & cmp_mk) + opc[i]) >> (2 * cmp_k)) : 32'd0);
`ifdef DSA_OVERFLOW_EN
        lit(i, "ovf", 32'(act_ovf[i]), 32'(e_ovf[i]));
`endif
      end
    end
  end

  // One directed add on the WIDTH=8 instance with hand-computed results and per-digit slice carries.
  task automatic add8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input logic [3:0] ecins, input string nm);
    int lat;
    logic [3:0] cins;
    @(posedge clk); #1;
    a_d[0] = xa; b_d[0] = xb; cin_d[0] = xc; start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    a_d[0] = 8'($urandom); b_d[0] = 8'($urandom); cin_d[0] = 1'($urandom);
    cins = '0;
    for (lat = 0; lat < 20; lat++) begin
      @(negedge clk);
      if (if8.done === 1'b1) break;
      if (if8.busy === 1'b1) cins = {cins[2:0], sc8};
    end
    lit(0, {nm, "_latency"}, 32'(lat), 32'd4);
    lit(0, {nm, "_sum"}, 32'(if8.sum), 32'(es));
    lit(0, {nm, "_cout"}, 32'(if8.cout), 32'(ec));
    lit(0, {nm, "_slice_cin_seq"}, 32'(cins), 32'(ecins));
`ifdef DSA_OVERFLOW_EN
    lit(0, {nm, "_ovf"}, 32'(if8.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected unknown overflow expectation for %s", nm);
`endif
  endtask

  initial begin : w8_stim
    int ndone, last_done;
    logic [7:0] got_sum;
    logic       got_cout;
    rst_n_d[0] = 1'b0; start_d[0] = 1'b0; a_d[0] = 8'h00; b_d[0] = 8'h00; cin_d[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n_d[0] = 1'b1;
    @(negedge clk);
    lit(0, "reset_ready", 32'(if8.ready), 32'd1);
    lit(0, "reset_busy",  32'(if8.busy),  32'd0);
    lit(0, "reset_done",  32'(if8.done),  32'd0);
    lit(0, "reset_sum",   32'(if8.sum),   32'd0);

    add8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 4'b0110, "basic");
    add8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 4'b1111, "chain_aa55");
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0111, "chain_ff01");
    add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4'b0111, "ovf_7f01");
    add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, "ovf_8080");

    // start held high with operands changing every cycle
    @(posedge clk); #1;
    start_d[0] = 1'b1;
    ndone = 0; last_done = -1;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      a_d[0] = 8'($urandom); b_d[0] = 8'($urandom); cin_d[0] = 1'($urandom);
      @(negedge clk);
      if (if8.done === 1'b1) begin
        if (last_done >= 0) lit(0, "hold_period", 32'(j - last_done), 32'd6);
        last_done = j;
        ndone++;
      end
    end
    start_d[0] = 1'b0;
    lit(0, "hold_done_count", 32'(ndone), 32'd5);

    // start pulsed during RUN with other operands must be ignored
    @(posedge clk); #1;
    a_d[0] = 8'h12; b_d[0] = 8'h34; cin_d[0] = 1'b0; start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    @(posedge clk); #1;
    a_d[0] = 8'hFF; b_d[0] = 8'hFF; cin_d[0] = 1'b1; start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    ndone = 0; got_sum = '0; got_cout = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (if8.done === 1'b1) begin
        ndone++;
        got_sum = if8.sum;
        got_cout = if8.cout;
      end
    end
    lit(0, "ignore_start_dones", 32'(ndone), 32'd1);
    lit(0, "ignore_start_sum", 32'(got_sum), 32'h46);
    lit(0, "ignore_start_cout", 32'(got_cout), 32'd0);

    // reset after two RUN digits discards the add
    @(posedge clk); #1;
    a_d[0] = 8'h5A; b_d[0] = 8'h33; cin_d[0] = 1'b1; start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n_d[0] = 1'b0;
    @(posedge clk); #1;
    rst_n_d[0] = 1'b1;
    @(negedge clk);
    lit(0, "midreset_ready", 32'(if8.ready), 32'd1);
    lit(0, "midreset_busy",  32'(if8.busy),  32'd0);
    lit(0, "midreset_sum",   32'(if8.sum),   32'd0);
    lit(0, "midreset_cout",  32'(if8.cout),  32'd0);
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (if8.done === 1'b1) ndone++;
    end
    lit(0, "midreset_no_done", 32'(ndone), 32'd0);
    add8(8'h3C, 8'h03, 1'b0, 8'h3F, 1'b0, 1'b0, 4'b0000, "after_reset");

    // random traffic with occasional resets
    for (int j = 0; j < 1500; j++) begin
      @(posedge clk); #1;
      start_d[0] = ($urandom_range(0, 2) != 0);
      a_d[0]     = 8'($urandom);
      b_d[0]     = 8'($urandom);
      cin_d[0]   = 1'($urandom);
      rst_n_d[0] = ($urandom_range(0, 39) != 0);
    end
    @(posedge clk); #1;
    rst_n_d[0] = 1'b1; start_d[0] = 1'b0;
    repeat (8) @(posedge clk);

    for (int t = 0; t < 5000 && !fin2; t++) @(posedge clk);
    lit(0, "w2_bench_finished", 32'(fin2), 32'd1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : w2_stim
    int lat;
    rst_n_d[1] = 1'b0; start_d[1] = 1'b0; a_d[1] = 8'h00; b_d[1] = 8'h00; cin_d[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n_d[1] = 1'b1;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        for (int c = 0; c < 2; c++) begin
          @(posedge clk); #1;
          a_d[1] = 8'(x); b_d[1] = 8'(y); cin_d[1] = 1'(c); start_d[1] = 1'b1;
          @(posedge clk); #1;
          start_d[1] = 1'b0;
          for (lat = 0; lat < 10; lat++) begin
            @(negedge clk);
            if (if2.done === 1'b1) break;
          end
          lit(1, "exh_latency", 32'(lat), 32'd1);
          lit(1, "exh_result", 32'({if2.cout, if2.sum}), 32'(x + y + c));
        end
      end
    end
    for (int j = 0; j < 400; j++) begin
      @(posedge clk); #1;
      start_d[1] = 1'($urandom);
      a_d[1]     = 8'($urandom);
      b_d[1]     = 8'($urandom);
      cin_d[1]   = 1'($urandom);
      rst_n_d[1] = ($urandom_range(0, 29) != 0);
    end
    @(posedge clk); #1;
    rst_n_d[1] = 1'b1; start_d[1] = 1'b0;
    fin2 = 1'b1;
  end

endmodule
